// File: rtl/configs_loader.sv
// Write-side sequencer for the configuration latch bank: takes words over valid/ready,
// drives them on a shared bus and strobes one latch enable per word with setup/hold margins.
module configs_loader #(
    parameter int WORDS = 29,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_start,
    input  logic [WIDTH-1:0] io_word_in,
    input  logic             io_word_valid,
    output logic             io_word_ready,
    output logic [WIDTH-1:0] io_d_out,
    output logic [WORDS-1:0] io_configs_en,
    output logic             io_busy,
    output logic             io_done,
    output logic [2:0]       io_state_dbg
);

    localparam int IDXW = $clog2(WORDS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_SETUP  = 3'd2,
        S_STROBE = 3'd3,
        S_HOLD   = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WORDS-1:0] en_q, en_d;

    // Handshake: a word transfers on a rising edge where io_word_valid and
    // io_word_ready are both high; io_word_ready is high exactly while in WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (io_start) state_d = S_WAIT;
            S_WAIT:   if (io_word_valid) state_d = S_SETUP;
            S_SETUP:  state_d = S_STROBE;
            S_STROBE: state_d = S_HOLD;
            S_HOLD:   state_d = (idx_q == LAST_IDX) ? S_DONE : S_WAIT;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q  <= '0;
            data_q <= '0;
            en_q   <= '0;
        end else begin
            idx_q  <= idx_d;
            data_q <= data_d;
            en_q   <= en_d;
        end
    end

    // Enables default to zero so only the SETUP->STROBE transition can raise one bit.
    always_comb begin
        idx_d  = idx_q;
        data_d = data_q;
        en_d   = '0;
        case (state_q)
            S_IDLE:  if (io_start) idx_d = '0;
            S_WAIT:  if (io_word_valid) data_d = io_word_in;
            S_SETUP: en_d = WORDS'(1) << idx_q;
            S_HOLD:  if (idx_q != LAST_IDX) idx_d = idx_q + 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        io_word_ready = (state_q == S_WAIT);
        io_busy       = (state_q != S_IDLE);
        io_done       = (state_q == S_DONE);
        io_d_out      = data_q;
        io_configs_en = en_q;
        io_state_dbg  = state_q;
    end

endmodule
